// File: rtl/and_gate_bist_checker_pkg.sv
// Shared types and helpers for the 2-input AND gate self-test checker.
package and_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    FINISH
  } bist_state_e;

  localparam int unsigned NUM_VECTORS = 4;

  function automatic logic expected_y(input logic [1:0] vec);
    return vec[1] & vec[0];
  endfunction

endpackage

// File: rtl/and_gate_bist_checker_settle_timer.sv
// Loadable down-counter with zero flag; paces stimulus settle intervals.
module settle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/and_gate_bist_checker.sv
// Exhaustive stimulus/response self-test for a 2-input AND gate; all outputs registered.
module and_gate_bist_checker
  import and_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int unsigned TMR_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [1:0]  LAST_VEC = 2'(NUM_VECTORS - 1);

  bist_state_e state;
  logic [1:0]  vec_idx;
  logic [1:0]  vec_next;
  logic        mismatch;
  logic        tmr_load;
  logic        tmr_dec;
  logic        tmr_zero;

  settle_timer #(
    .WIDTH (TMR_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_W'(SETTLE_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Case inequality so an unknown y_i at sample time counts as a mismatch.
  always_comb begin
    vec_next = vec_idx + 2'd1;
    mismatch = (y_i !== expected_y({a_o, b_o}));
    tmr_load = (state == APPLY);
    tmr_dec  = (state == SETTLE);
  end

  // Stimulus is registered on entry to APPLY so it is stable for the whole vector window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= '0;
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= APPLY;
            busy       <= 1'b1;
            vec_idx    <= '0;
            a_o        <= 1'b0;
            b_o        <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        APPLY: state <= SETTLE;
        SETTLE: begin
          if (tmr_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec_idx;
            end
          end
          if (vec_idx == LAST_VEC) begin
            state <= FINISH;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
            a_o   <= 1'b0;
            b_o   <= 1'b0;
          end else begin
            state      <= APPLY;
            vec_idx    <= vec_next;
            {a_o, b_o} <= vec_next;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
